pipeline_io_ctrl: RTL and testbench
===================================

// Module: pipeline_io_ctrl
// PURPOSE
//  Board-side I/O stage that sits directly downstream of the top-level pipeline.
//  It debounces the single-step button into a one-cycle step_pulse, which is used to gate or advance the pipeline clock.
//  It synchronises the 5-bit register-select switches that drive the pipeline's register_switch input.
//  It scans a 4-digit, active-low, seven-segment display showing pc_out or register_out in hex.
// PARAMETERS
//  DB_CYCLES    100000  consecutive stable cycles needed to accept a button level change (>=2)
//  SCAN_CYCLES  100000  clock cycles each digit stays lit (>=2)
// PORTS
//  clock         in   1   system clock, all logic on rising edge
//  reset         in   1   synchronous, active-high reset
//  btn_step      in   1   raw asynchronous step button, high = pressed
//  sw_reg        in   5   raw register-select switches
//  sw_show_reg   in   1   0: show pc_out, 1: show register_out
//  sw_upper      in   1   0: show bits [15:0], 1: show bits [31:16]
//  pc_out        in   32  PC from pipeline
//  register_out  in   32  selected register value from pipeline
//  step_pulse    out  1   one-cycle pulse per debounced press
//  reg_sel       out  5   synchronised sw_reg, drives pipeline register_switch
//  an            out  4   digit enables, active low, an[0] = rightmost digit
//  seg           out  7   {g,f,e,d,c,b,a}, active low
// BEHAVIOUR
//  Reset values (every output and state register):
//   step_pulse=0, reg_sel=0, an=4'b1111, seg=7'b1111111.
//   sync flops=0, debounced state=0, debounce counter=0, scan counter=0, digit index=0.
//  Input synchronisation:
//   btn_step, sw_reg, sw_show_reg and sw_upper each pass through 2 flops.
//   reg_sel equals sw_reg as sampled 2 rising edges earlier.
//  Debounce:
//   Counter increments while sync_btn != db_state and clears to 0 whenever they are equal.
//   When the counter reaches DB_CYCLES-1 with a mismatch: db_state <= sync_btn and counter <= 0.
//   step_pulse is registered; it is 1 only for the cycle following a 0->1 db_state update.
//   Latency: after btn_step is first sampled high and held, step_pulse is high after rising edge DB_CYCLES+2.
//   A bounce shorter than DB_CYCLES restarts the count. Holding gives no repeat; release gives no pulse.
//   Reset mid-count discards the partial count.
//  Display value:
//   val = sync_show_reg ? register_out : pc_out, sampled each cycle.
//   half = sync_upper ? val[31:16] : val[15:0].
//   nibble = half[4*digit +: 4].
//  Scan:
//   The scan counter counts 0..SCAN_CYCLES-1 and wraps.
//   On wrap, digit increments mod 4 (3 -> 0).
//   an and seg are registered: the edge that updates digit also updates an = ~(4'b0001 << digit) and seg = decode(nibble) together.
//   Exactly one an bit is low after the first post-reset edge; an is never 0000.
//   No blanking of leading zeros. Decimal point is not driven.
//  Hex decode (seg):
//   0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//   8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110
//  Input changes (switches, pc_out) update the lit digit on the next edge after sync; they never disturb the scan counter.
// TESTING (bench uses DB_CYCLES=4, SCAN_CYCLES=3)
//  1) Hold reset 3 cycles -> an=1111, seg=1111111, step_pulse=0, reg_sel=0.
//     First edge after release -> an=1110.
//  2) btn_step 1 for 3 cycles, then 0 -> no step_pulse ever.
//     btn_step 1 held -> exactly one step_pulse, high after edge 6, low after edge 7.
//  3) Continue holding btn_step 50 cycles -> no further pulse.
//     Release -> no pulse. Press again -> one pulse.
//  4) pc_out=32'h0000_12AF, sw_show_reg=0, sw_upper=0:
//     an 1110/seg 0001110, then 1101/0001000, then 1011/0100100, then 0111/1111001.
//     Each held 3 cycles; wraps back to 1110.
//  5) register_out=32'hC0DE_0000, sw_show_reg=1, sw_upper=1 -> digits 0..3 show E,d,0,C.
//     Toggling sw_upper mid-scan changes seg 3 edges later without shifting the an sequence.
//  6) sw_reg=5'd17 -> reg_sel=17 after 2 edges.
//     Assert reset mid-debounce (count=2) -> after release, press needs a full DB_CYCLES again.

Source files
------------

// File: rtl/pipeline_io_ctrl.sv
// Board-side I/O stage for the pipeline: step-button debounce, switch
// synchronisation and a 4-digit multiplexed seven-segment hex display.
module pipeline_io_ctrl #(
  parameter int DB_CYCLES   = 100000,
  parameter int SCAN_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_step,
  input  logic [4:0]  sw_reg,
  input  logic        sw_show_reg,
  input  logic        sw_upper,
  input  logic [31:0] pc_out,
  input  logic [31:0] register_out,
  output logic        step_pulse,
  output logic [4:0]  reg_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int DB_W   = (DB_CYCLES   > 2) ? $clog2(DB_CYCLES)   : 1;
  localparam int SCAN_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);

  // Two-flop synchronisers for every asynchronous board input
  logic       r_btn_s1, r_btn_s2;
  logic [4:0] r_sw_s1, r_sw_s2;
  logic       r_show_s1, r_show_s2;
  logic       r_upper_s1, r_upper_s2;

  // Debounce state
  logic            r_db_state;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_step_pulse;

  // Scan state and registered display outputs
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_digit;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;

  logic        w_db_mismatch;
  logic        w_db_done;
  logic        w_scan_wrap;
  logic [1:0]  w_digit_next;
  logic [31:0] w_val;
  logic [15:0] w_half;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg_dec;

  // Synchronise button and switches through two flops each
  always_ff @(posedge clock) begin
    if (reset) begin
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_sw_s1    <= 5'd0;
      r_sw_s2    <= 5'd0;
      r_show_s1  <= 1'b0;
      r_show_s2  <= 1'b0;
      r_upper_s1 <= 1'b0;
      r_upper_s2 <= 1'b0;
    end else begin
      r_btn_s1   <= btn_step;
      r_btn_s2   <= r_btn_s1;
      r_sw_s1    <= sw_reg;
      r_sw_s2    <= r_sw_s1;
      r_show_s1  <= sw_show_reg;
      r_show_s2  <= r_show_s1;
      r_upper_s1 <= sw_upper;
      r_upper_s2 <= r_upper_s1;
    end
  end

  assign w_db_mismatch = (r_btn_s2 != r_db_state);
  assign w_db_done     = w_db_mismatch && (r_db_cnt == DB_MAX);

  // Accept a new button level only after DB_CYCLES consecutive mismatches;
  // pulse once on the edge that accepts a press
  always_ff @(posedge clock) begin
    if (reset) begin
      r_db_state   <= 1'b0;
      r_db_cnt     <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= w_db_done && r_btn_s2;
      if (!w_db_mismatch) begin
        r_db_cnt <= '0;
      end else if (w_db_done) begin
        r_db_state <= r_btn_s2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_scan_wrap  = (r_scan_cnt == SCAN_MAX);
  // Two-bit index wraps 3 -> 0 naturally
  assign w_digit_next = w_scan_wrap ? (r_digit + 2'd1) : r_digit;

  assign w_val  = r_show_s2 ? register_out : pc_out;
  assign w_half = r_upper_s2 ? w_val[31:16] : w_val[15:0];

  // Pick the nibble for the digit that will be lit after this edge
  always_comb begin
    w_nibble = w_half[3:0];
    case (w_digit_next)
      2'd0: w_nibble = w_half[3:0];
      2'd1: w_nibble = w_half[7:4];
      2'd2: w_nibble = w_half[11:8];
      2'd3: w_nibble = w_half[15:12];
      default: w_nibble = w_half[3:0];
    endcase
  end

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}
  always_comb begin
    w_seg_dec = 7'b1111111;
    case (w_nibble)
      4'h0: w_seg_dec = 7'b1000000;
      4'h1: w_seg_dec = 7'b1111001;
      4'h2: w_seg_dec = 7'b0100100;
      4'h3: w_seg_dec = 7'b0110000;
      4'h4: w_seg_dec = 7'b0011001;
      4'h5: w_seg_dec = 7'b0010010;
      4'h6: w_seg_dec = 7'b0000010;
      4'h7: w_seg_dec = 7'b1111000;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0010000;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b0000011;
      4'hC: w_seg_dec = 7'b1000110;
      4'hD: w_seg_dec = 7'b0100001;
      4'hE: w_seg_dec = 7'b0000110;
      4'hF: w_seg_dec = 7'b0001110;
      default: w_seg_dec = 7'b1111111;
    endcase
  end

  // Free-running digit scan; an/seg refresh every edge from the next digit so
  // anode and segment pattern always change together
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_digit    <= 2'd0;
      r_an       <= 4'b1111;
      r_seg      <= 7'b1111111;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : (r_scan_cnt + 1'b1);
      r_digit    <= w_digit_next;
      r_an       <= ~(4'b0001 << w_digit_next);
      r_seg      <= w_seg_dec;
    end
  end

  assign step_pulse = r_step_pulse;
  assign reg_sel    = r_sw_s2;
  assign an         = r_an;
  assign seg        = r_seg;

endmodule

// File: tb/tb_pipeline_io_ctrl.sv
// Self-checking bench for pipeline_io_ctrl with a history-based reference model.
module tb_pipeline_io_ctrl;

  localparam int DB = 4;
  localparam int SC = 3;
  localparam int HMAX = 4096;

  logic        clock;
  logic        reset;
  logic        btn_step;
  logic [4:0]  sw_reg;
  logic        sw_show_reg;
  logic        sw_upper;
  logic [31:0] pc_out;
  logic [31:0] register_out;
  logic        step_pulse;
  logic [4:0]  reg_sel;
  logic [3:0]  an;
  logic [6:0]  seg;

  pipeline_io_ctrl #(.DB_CYCLES(DB), .SCAN_CYCLES(SC)) dut (
    .clock(clock), .reset(reset), .btn_step(btn_step), .sw_reg(sw_reg),
    .sw_show_reg(sw_show_reg), .sw_upper(sw_upper), .pc_out(pc_out),
    .register_out(register_out), .step_pulse(step_pulse), .reg_sel(reg_sel),
    .an(an), .seg(seg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        btn;
    logic [4:0]  sw;
    logic        show;
    logic        upper;
    logic [31:0] pc;
    logic [31:0] rg;
  } in_s;

  in_s hist [HMAX];
  int  n;            // edges since reset release
  logic m_db;        // model's accepted button level
  int  tests_run;
  int  failed;
  int  pulse_cnt;
  int  pulse_n;

  logic       exp_pulse;
  logic [4:0] exp_reg;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  // Input as seen at edge k; edges at or before reset release read as zero
  function automatic in_s at(input int k);
    in_s z;
    z = '0;
    if (k >= 1) return hist[k];
    return z;
  endfunction

  task automatic tick();
    logic rst_edge;
    logic acc;
    int   e;
    int   digit;
    in_s  s;
    in_s  now;
    logic [31:0] val;
    logic [15:0] half;
    logic [3:0]  nib;
    rst_edge = reset;
    e = n + 1;
    if (!rst_edge) begin
      if (e >= HMAX) begin
        $display("FAIL history_overflow got=%0d exp<%0d", e, HMAX);
        $fatal(1);
      end
      hist[e].btn   = btn_step;
      hist[e].sw    = sw_reg;
      hist[e].show  = sw_show_reg;
      hist[e].upper = sw_upper;
      hist[e].pc    = pc_out;
      hist[e].rg    = register_out;
    end
    @(posedge clock);
    #1;
    if (rst_edge) begin
      n = 0;
      m_db = 1'b0;
      exp_pulse = 1'b0;
      exp_reg = 5'd0;
      exp_an = 4'b1111;
      exp_seg = 7'b1111111;
    end else begin
      n = e;
      // A level is accepted once the synchronised button has disagreed with
      // the accepted level for DB consecutive edges (sync delay = 2 edges)
      acc = (n >= DB);
      for (int j = 0; j < DB; j++)
        if (at(n - j - 2).btn == m_db) acc = 1'b0;
      exp_pulse = acc && !m_db;
      if (acc) m_db = ~m_db;
      exp_reg = at(n - 1).sw;
      digit = (n / SC) % 4;
      exp_an = ~(4'b0001 << digit);
      s = at(n - 2);
      now = at(n);
      val = s.show ? now.rg : now.pc;
      half = s.upper ? val[31:16] : val[15:0];
      nib = 4'(half >> (4 * digit));
      exp_seg = hex7(nib);
    end
    if (step_pulse === 1'b1) begin
      pulse_cnt++;
      pulse_n = n;
    end
    tests_run++;
    assert (step_pulse === exp_pulse) else begin
      failed++;
      $error("FAIL step_pulse n=%0d got=%0b exp=%0b", n, step_pulse, exp_pulse);
    end
    tests_run++;
    assert (reg_sel === exp_reg) else begin
      failed++;
      $error("FAIL reg_sel n=%0d got=%0d exp=%0d", n, reg_sel, exp_reg);
    end
    tests_run++;
    assert (an === exp_an) else begin
      failed++;
      $error("FAIL an n=%0d got=%b exp=%b", n, an, exp_an);
    end
    tests_run++;
    assert (seg === exp_seg) else begin
      failed++;
      $error("FAIL seg n=%0d got=%b exp=%b", n, seg, exp_seg);
    end
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int start;
    int run;
    tests_run = 0; failed = 0; pulse_cnt = 0; pulse_n = -1;
    n = 0; m_db = 1'b0;
    reset = 1'b1; btn_step = 1'b0; sw_reg = 5'd0; sw_show_reg = 1'b0;
    sw_upper = 1'b0; pc_out = 32'd0; register_out = 32'd0;

    // 1) reset state, then first edge lights digit 0
    ticks(3);
    reset = 1'b0;
    tick();
    tests_run++;
    assert (an === 4'b1110) else begin
      failed++;
      $error("FAIL first_an got=%b exp=1110", an);
    end

    // 2) short bounce gives nothing; held press gives one pulse after edge 6
    btn_step = 1'b1; ticks(3);
    btn_step = 1'b0; ticks(10);
    tests_run++;
    assert (pulse_cnt === 0) else begin
      failed++;
      $error("FAIL bounce_pulses got=%0d exp=0", pulse_cnt);
    end
    start = n; pulse_cnt = 0;
    btn_step = 1'b1; ticks(8);
    tests_run++;
    assert (pulse_cnt === 1 && pulse_n - start === DB + 2) else begin
      failed++;
      $error("FAIL press_latency got=%0d/%0d exp=1/%0d", pulse_cnt, pulse_n - start, DB + 2);
    end

    // 3) hold gives no repeat, release gives nothing, new press gives one
    pulse_cnt = 0; ticks(50);
    btn_step = 1'b0; ticks(20);
    tests_run++;
    assert (pulse_cnt === 0) else begin
      failed++;
      $error("FAIL hold_release_pulses got=%0d exp=0", pulse_cnt);
    end
    btn_step = 1'b1; ticks(10);
    tests_run++;
    assert (pulse_cnt === 1) else begin
      failed++;
      $error("FAIL repress_pulses got=%0d exp=1", pulse_cnt);
    end
    btn_step = 1'b0; ticks(10);

    // 4) pc_out lower half F,A,2,1 across the four digits
    pc_out = 32'h0000_12AF; sw_show_reg = 1'b0; sw_upper = 1'b0;
    reset = 1'b1; ticks(2); reset = 1'b0;
    tick();
    tests_run++;
    assert (an === 4'b1110 && seg === 7'b0001110) else begin
      failed++;
      $error("FAIL pc_digit0 got=%b/%b exp=1110/0001110", an, seg);
    end
    ticks(5);
    tests_run++;
    assert (an === 4'b1011 && seg === 7'b0100100) else begin
      failed++;
      $error("FAIL pc_digit2 got=%b/%b exp=1011/0100100", an, seg);
    end
    ticks(20);

    // 5) register_out upper half, then toggle sw_upper mid-scan
    register_out = 32'hC0DE_0000; sw_show_reg = 1'b1; sw_upper = 1'b1;
    ticks(24);
    sw_upper = 1'b0; ticks(7);
    sw_upper = 1'b1; ticks(10);

    // 6) switch sync latency, and reset mid-debounce discards the count
    sw_reg = 5'd17; ticks(2);
    tests_run++;
    assert (reg_sel === 5'd17) else begin
      failed++;
      $error("FAIL reg_sel_17 got=%0d exp=17", reg_sel);
    end
    btn_step = 1'b1; ticks(4);
    reset = 1'b1; ticks(2); reset = 1'b0;
    pulse_cnt = 0; pulse_n = -1;
    ticks(8);
    tests_run++;
    assert (pulse_cnt === 1 && pulse_n === DB + 2) else begin
      failed++;
      $error("FAIL reset_mid_debounce got=%0d/%0d exp=1/%0d", pulse_cnt, pulse_n, DB + 2);
    end
    btn_step = 1'b0; ticks(8);

    // Randomised phase: bursty button, changing switches and data every cycle
    for (int i = 0; i < 60; i++) begin
      run = $urandom_range(1, 8);
      btn_step = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        sw_reg = 5'($urandom);
        sw_show_reg = 1'($urandom);
        sw_upper = 1'($urandom);
      end
      for (int k = 0; k < run; k++) begin
        pc_out = $urandom;
        register_out = $urandom;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
